// File: rtl/smart_home_pkg.sv
// Shared definitions for the smart-home access controller: FSM state
// encodings and the factory password loaded into every zone at reset.
package smart_home_pkg;

    // Encodings are visible on dbg_state, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PW = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    localparam int STATE_W = 3;

    // Factory password for every zone.
    localparam logic [7:0] DEFAULT_PW = 8'hA5;

endpackage

// File: rtl/access_lock_timer.sv
// Lockout countdown. A start pulse arms the timer; done pulses high during
// the LOCK_CYCLES-th cycle after start, so the owner spends exactly
// LOCK_CYCLES cycles in lockout if it leaves on done. clr disarms it.
module access_lock_timer
    import smart_home_pkg::*;
#(
    parameter  int LOCK_CYCLES = 16,
    localparam int CW          = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1)
) (
    input  logic clk,
    input  logic arst,
    input  logic start,
    input  logic clr,
    output logic done
);

    logic [CW-1:0] cnt;
    logic          run;

    // done is decoded from registered state, so it is glitch-free and
    // lands in the same cycle the owner decides to leave lockout.
    assign done = run && (cnt == '0);

    // Load on start, count down while armed, disarm on done or clear.
    always_ff @(posedge clk) begin
        if (!arst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(LOCK_CYCLES - 1);
        end else if (clr || done) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/smart_access_ctrl.sv
// Smart-home access controller: a password session FSM guarding NUM_ZONES
// zones, with consecutive-failure counting and a timed lockout.
// Optional feature: define ACCESS_CFG_WRITE_EN to add the cfg_* ports that
// let zone passwords be rewritten while the controller is idle; without it
// every zone password is the constant DEFAULT_PW.
module smart_access_ctrl #(
    parameter  int                  PW_WIDTH    = 8,
    parameter  int                  NUM_ZONES   = 4,
    parameter  int                  MAX_TRIES   = 3,
    parameter  int                  LOCK_CYCLES = 16,
    parameter  logic [PW_WIDTH-1:0] DEFAULT_PW  = smart_home_pkg::DEFAULT_PW,
    localparam int                  ZW          = $clog2(NUM_ZONES),
    localparam int                  FW          = $clog2(MAX_TRIES + 1)
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 request,
    input  logic                 confirm,
    input  logic [PW_WIDTH-1:0]  password,
    input  logic [ZW-1:0]        zone,
`ifdef ACCESS_CFG_WRITE_EN
    input  logic                 cfg_we,
    input  logic [ZW-1:0]        cfg_zone,
    input  logic [PW_WIDTH-1:0]  cfg_pw,
`endif
    output logic [NUM_ZONES-1:0] grant,
    output logic                 alarm,
    output logic [FW-1:0]        fail_cnt,
    output logic [2:0]           dbg_state
);

    import smart_home_pkg::*;

    state_e                               state;
    logic [PW_WIDTH-1:0]                  cap_pw;
    logic [ZW-1:0]                        cap_zone;
    logic [NUM_ZONES-1:0][PW_WIDTH-1:0]   zone_pw;
    logic [NUM_ZONES-1:0]                 grant_nxt;
    logic [FW-1:0]                        fail_nxt;
    logic                                 pw_match;
    logic                                 lock_start;
    logic                                 lock_clr;
    logic                                 lock_done;

    assign dbg_state = state;

`ifdef ACCESS_CFG_WRITE_EN
    // Writable password store; writes only land while idle so a session in
    // flight always checks against a stable password.
    always_ff @(posedge clk) begin
        if (!arst) begin
            for (int z = 0; z < NUM_ZONES; z++) zone_pw[z] <= DEFAULT_PW;
        end else if (cfg_we && (state == ST_IDLE)) begin
            // Out-of-range cfg_zone matches no entry and is dropped.
            for (int z = 0; z < NUM_ZONES; z++)
                if (cfg_zone == ZW'(z)) zone_pw[z] <= cfg_pw;
        end
    end
`else
    // Fixed password store.
    always_comb begin
        for (int z = 0; z < NUM_ZONES; z++) zone_pw[z] = DEFAULT_PW;
    end
`endif

    // Compare against the captured zone; an index past the last zone
    // selects nothing and therefore reads as a mismatch.
    always_comb begin
        pw_match = 1'b0;
        for (int z = 0; z < NUM_ZONES; z++)
            if ((cap_zone == ZW'(z)) && (cap_pw == zone_pw[z])) pw_match = 1'b1;
    end

    // One-hot decode of the captured zone for the grant register.
    always_comb begin
        grant_nxt = '0;
        for (int z = 0; z < NUM_ZONES; z++)
            if (cap_zone == ZW'(z)) grant_nxt[z] = 1'b1;
    end

    // Saturating next failure count, used while in FAIL.
    assign fail_nxt = (fail_cnt >= FW'(MAX_TRIES)) ? FW'(MAX_TRIES)
                                                   : fail_cnt + FW'(1);

    // Arm the lockout timer on the FAIL edge that reaches MAX_TRIES; keep it
    // cleared in every state other than LOCKOUT.
    assign lock_start = (state == ST_FAIL) && (fail_nxt == FW'(MAX_TRIES));
    assign lock_clr   = (state != ST_LOCKOUT);

    access_lock_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_timer (
        .clk   (clk),
        .arst  (arst),
        .start (lock_start),
        .clr   (lock_clr),
        .done  (lock_done)
    );

    // Session FSM with registered grant/alarm/fail_cnt.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            alarm    <= 1'b0;
            fail_cnt <= '0;
            cap_pw   <= '0;
            cap_zone <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    grant <= '0;
                    alarm <= 1'b0;
                    if (request) state <= ST_WAIT_PW;
                end
                ST_WAIT_PW: begin
                    // Dropping request aborts without counting as a failure.
                    if (!request) begin
                        state <= ST_IDLE;
                    end else if (confirm) begin
                        cap_pw   <= password;
                        cap_zone <= zone;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (pw_match) begin
                        state    <= ST_GRANTED;
                        grant    <= grant_nxt;
                        fail_cnt <= '0;
                    end else begin
                        state <= ST_FAIL;
                    end
                end
                ST_GRANTED: begin
                    if (!request) begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
                ST_FAIL: begin
                    fail_cnt <= fail_nxt;
                    if (lock_start) begin
                        state <= ST_LOCKOUT;
                        alarm <= 1'b1;
                    end else if (request) begin
                        state <= ST_WAIT_PW;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    // Inputs are ignored until the timer expires.
                    if (lock_done) begin
                        state    <= ST_IDLE;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: begin
                    // Unused encodings recover to the reset condition.
                    state    <= ST_IDLE;
                    grant    <= '0;
                    alarm    <= 1'b0;
                    fail_cnt <= '0;
                    cap_pw   <= '0;
                    cap_zone <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smart_access_ctrl.sv
// Self-checking bench for smart_access_ctrl at default parameters.
// Build with +define+ACCESS_CFG_WRITE_EN to also cover password writes.
module tb_smart_access_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       request = 1'b0;
    logic       confirm = 1'b0;
    logic [7:0] password = 8'h00;
    logic [1:0] zone = 2'd0;
    logic [3:0] grant;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [2:0] dbg_state;
`ifdef ACCESS_CFG_WRITE_EN
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_zone = 2'd0;
    logic [7:0] cfg_pw = 8'h00;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CHECK = 3'd2,
                           S_GRANT = 3'd3, S_FAIL = 3'd4, S_LOCK = 3'd5;

    typedef struct packed {
        logic [3:0] g;
        logic       a;
        logic [1:0] f;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       req;
        logic       conf;
        logic [7:0] pw;
        logic [1:0] zn;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[21];

    smart_access_ctrl dut (
        .clk       (clk),
        .arst      (arst),
        .request   (request),
        .confirm   (confirm),
        .password  (password),
        .zone      (zone),
`ifdef ACCESS_CFG_WRITE_EN
        .cfg_we    (cfg_we),
        .cfg_zone  (cfg_zone),
        .cfg_pw    (cfg_pw),
`endif
        .grant     (grant),
        .alarm     (alarm),
        .fail_cnt  (fail_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string name, logic rst_n, logic req, logic conf,
                                logic [7:0] pw, logic [1:0] zn, logic [3:0] g,
                                logic a, logic [1:0] f, logic [2:0] st);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.req = req; v.conf = conf;
        v.pw = pw; v.zn = zn;
        v.e.g = g; v.e.a = a; v.e.f = f; v.e.st = st;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare them one step after the rising edge.
    task automatic step(input vec_t v);
        exp_t e, act;
        arst = v.rst_n; request = v.req; confirm = v.conf;
        password = v.pw; zone = v.zn;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        act = '{grant, alarm, fail_cnt, dbg_state};
        n_chk++;
        if (act == e) n_pass++;
        else $display("FAIL %s: got grant=%b alarm=%b fail_cnt=%0d state=%0d, want grant=%b alarm=%b fail_cnt=%0d state=%0d",
                      v.name, act.g, act.a, act.f, act.st, e.g, e.a, e.f, e.st);
    endtask

    task automatic st(input string name, input logic rst_n, input logic req,
                      input logic conf, input logic [7:0] pw, input logic [1:0] zn,
                      input logic [3:0] g, input logic a, input logic [1:0] f,
                      input logic [2:0] s);
        step(mk(name, rst_n, req, conf, pw, zn, g, a, f, s));
    endtask

    // From IDLE with fail_cnt=0: three wrong passwords ending in LOCKOUT.
    task automatic enter_lockout(input string tag);
        st({tag, "_wait"}, 1, 1, 0, 8'h00, 2'd0, 4'b0, 0, 2'd0, S_WAIT);
        for (int k = 1; k <= 3; k++) begin
            st({tag, "_chk"},  1, 1, 1, 8'h00, 2'd0, 4'b0, 0, 2'(k - 1), S_CHECK);
            st({tag, "_fail"}, 1, 1, 0, 8'h00, 2'd0, 4'b0, 0, 2'(k - 1), S_FAIL);
            if (k < 3)
                st({tag, "_retry"}, 1, 1, 0, 8'h00, 2'd0, 4'b0, 0, 2'(k), S_WAIT);
            else
                st({tag, "_enter"}, 1, 1, 1, 8'hA5, 2'd0, 4'b0, 1, 2'd3, S_LOCK);
        end
    endtask

    initial begin
        // Grant, abort and retry-then-grant sequences.
        tbl[0]  = mk("rst",        0, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        tbl[1]  = mk("g_req",      1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        tbl[2]  = mk("g_conf",     1, 1, 1, 8'hA5, 2'd2, 4'b0000, 0, 2'd0, S_CHECK);
        tbl[3]  = mk("g_grant",    1, 1, 0, 8'h00, 2'd0, 4'b0100, 0, 2'd0, S_GRANT);
        tbl[4]  = mk("g_hold",     1, 1, 1, 8'h00, 2'd1, 4'b0100, 0, 2'd0, S_GRANT);
        tbl[5]  = mk("g_drop",     1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        tbl[6]  = mk("ab_req",     1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        tbl[7]  = mk("ab_drop",    1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        tbl[8]  = mk("f1_req",     1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        tbl[9]  = mk("f1_conf",    1, 1, 1, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_CHECK);
        tbl[10] = mk("f1_fail",    1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_FAIL);
        tbl[11] = mk("f1_retry",   1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd1, S_WAIT);
        tbl[12] = mk("ab_keepcnt", 1, 0, 1, 8'hA5, 2'd0, 4'b0000, 0, 2'd1, S_IDLE);
        tbl[13] = mk("f2_req",     1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd1, S_WAIT);
        tbl[14] = mk("f2_conf",    1, 1, 1, 8'h5A, 2'd3, 4'b0000, 0, 2'd1, S_CHECK);
        tbl[15] = mk("f2_fail",    1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd1, S_FAIL);
        tbl[16] = mk("f2_retry",   1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd2, S_WAIT);
        tbl[17] = mk("ok_conf",    1, 1, 1, 8'hA5, 2'd1, 4'b0000, 0, 2'd2, S_CHECK);
        tbl[18] = mk("ok_grant",   1, 1, 0, 8'h00, 2'd0, 4'b0010, 0, 2'd0, S_GRANT);
        tbl[19] = mk("ok_drop",    1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        tbl[20] = mk("idle_conf",  1, 0, 1, 8'hA5, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);

        arst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) step(tbl[i]);

        // Full lockout: alarm for exactly 16 cycles, then IDLE with count 0.
        enter_lockout("lk");
        for (int i = 2; i <= 16; i++)
            st("lk_hold", 1, 1, 1, 8'hA5, 2'd2, 4'b0, 1, 2'd3, S_LOCK);
        st("lk_exit", 1, 0, 0, 8'h00, 2'd0, 4'b0, 0, 2'd0, S_IDLE);
        st("lk_idle", 1, 0, 0, 8'h00, 2'd0, 4'b0, 0, 2'd0, S_IDLE);

        // Reset in the middle of lockout.
        enter_lockout("rl");
        st("rl_hold", 1, 1, 0, 8'h00, 2'd0, 4'b0, 1, 2'd3, S_LOCK);
        st("rl_hold", 1, 1, 0, 8'h00, 2'd0, 4'b0, 1, 2'd3, S_LOCK);
        st("rl_rst",  0, 1, 0, 8'h00, 2'd0, 4'b0, 0, 2'd0, S_IDLE);
        st("rl_post", 1, 0, 0, 8'h00, 2'd0, 4'b0, 0, 2'd0, S_IDLE);

        // Reset in the middle of a granted session.
        st("rg_req",   1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        st("rg_conf",  1, 1, 1, 8'hA5, 2'd3, 4'b0000, 0, 2'd0, S_CHECK);
        st("rg_grant", 1, 1, 0, 8'h00, 2'd0, 4'b1000, 0, 2'd0, S_GRANT);
        st("rg_rst",   0, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        st("rg_post",  1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);

`ifdef ACCESS_CFG_WRITE_EN
        // Rewrite zone 1 while idle, then confirm old/new passwords.
        cfg_we = 1'b1; cfg_zone = 2'd1; cfg_pw = 8'h3C;
        st("cfg_wr", 1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        cfg_we = 1'b0;
        st("cfg_req",   1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        st("cfg_old",   1, 1, 1, 8'hA5, 2'd1, 4'b0000, 0, 2'd0, S_CHECK);
        st("cfg_oldf",  1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_FAIL);
        st("cfg_retry", 1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd1, S_WAIT);
        st("cfg_new",   1, 1, 1, 8'h3C, 2'd1, 4'b0000, 0, 2'd1, S_CHECK);
        st("cfg_grant", 1, 1, 0, 8'h00, 2'd0, 4'b0010, 0, 2'd0, S_GRANT);
        // Write attempted while granted must not land.
        cfg_we = 1'b1; cfg_zone = 2'd1; cfg_pw = 8'h77;
        st("cfg_busywr", 1, 1, 0, 8'h00, 2'd0, 4'b0010, 0, 2'd0, S_GRANT);
        cfg_we = 1'b0;
        st("cfg_drop",  1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
        st("cfg_req2",  1, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_WAIT);
        st("cfg_keep",  1, 1, 1, 8'h3C, 2'd1, 4'b0000, 0, 2'd0, S_CHECK);
        st("cfg_kept",  1, 1, 0, 8'h00, 2'd0, 4'b0010, 0, 2'd0, S_GRANT);
        st("cfg_end",   1, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 2'd0, S_IDLE);
`endif

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
